// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types -- shared types for the LC-3b datapath blocks.
//
//   lc3b_word        : 16-bit machine word, the default payload of rr_arb_mux
//   arb_mux_state_t  : arbiter FSM states (ARB = rotating search,
//                      LOCK = grant pinned to one channel)
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_mux_state_t;

endpackage : lc3b_types

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick -- rotating-priority request picker (purely combinational).
//
// Searches req starting at last_ch+1, wrapping CHANNELS-1 -> 0, and returns
// the first requester. The wrap is computed by subtraction, not by bit
// truncation, so non-power-of-two channel counts wrap correctly.
//
// Ports
//   req       in  [CHANNELS]  request vector
//   last_ch   in  [SEL_W]     most recently served channel (< CHANNELS)
//   grant     out [CHANNELS]  one-hot grant, all-zero when req == 0
//   grant_idx out [SEL_W]     index of the granted channel (0 when none)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int CHANNELS = 16,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    last_ch,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  always_comb begin
    int         idx;
    logic       found;
    logic [SEL_W-1:0] sel;
    // NOTE: every output and local gets a default before any conditional
    // assignment; a path that leaves one unassigned would infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      // last_ch < CHANNELS and k <= CHANNELS, so one subtraction wraps.
      idx = int'(last_ch) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      sel = idx[SEL_W-1:0];
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_arb_mux.sv
// ---------------------------------------------------------------------------
// rr_arb_mux -- round-robin arbitrated multiplexer with a one-beat output
// register.
//
// Each cycle one requesting channel is granted (rotating priority after the
// last served channel). The grant is accepted whenever the output register
// is empty or is being drained in the same cycle, so a full stream runs at
// one beat per cycle with no bubbles. A stalled output freezes all inputs.
//
// Optional feature (macro ARB_MUX_LOCK_EN): a channel that transfers with
// in_lock set keeps the grant exclusively until it transfers with in_lock
// clear. Without the macro the in_lock port and lock state do not exist and
// the arbiter is permanently in rotating-search mode.
//
// Ports
//   clk        in               rising-edge clock
//   rst_n      in               asynchronous active-low reset
//   in_valid   in  [CHANNELS]   per-channel request
//   in_data    in  [CHANNELS]x[WIDTH]  per-channel payload (unpacked)
//   in_ready   out [CHANNELS]   per-channel accept, one-hot or zero
//   in_lock    in  [CHANNELS]   hold grant after this beat (ARB_MUX_LOCK_EN)
//   out_valid  out              output register holds a beat
//   out_ready  in               downstream accepts the beat
//   out_data   out [WIDTH]      registered payload
//   out_sel    out [SEL_W]      channel index of the registered payload
// ---------------------------------------------------------------------------
module rr_arb_mux
  import lc3b_types::*;
#(
  parameter  int WIDTH    = $bits(lc3b_word),
  parameter  int CHANNELS = 16,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [WIDTH-1:0]    in_data [CHANNELS],
  output logic [CHANNELS-1:0] in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic [CHANNELS-1:0] in_lock,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [SEL_W-1:0]    out_sel
);

  // -------------------------------------------------------------------------
  // Output register and round-robin pointer
  // -------------------------------------------------------------------------
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic [SEL_W-1:0]   out_sel_q,   out_sel_d;
  logic [SEL_W-1:0]   last_ch_q,   last_ch_d;

  logic               load;
  logic               xfer;
  logic [CHANNELS-1:0] pick_grant;
  logic [SEL_W-1:0]    pick_idx;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;

  rr_pick #(
    .CHANNELS (CHANNELS)
  ) u_pick (
    .req       (in_valid),
    .last_ch   (last_ch_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  // -------------------------------------------------------------------------
  // Grant selection
  // -------------------------------------------------------------------------
`ifdef ARB_MUX_LOCK_EN
  arb_mux_state_t     state_q, state_d;
  logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  // Next-state logic. In LOCK every transfer comes from lock_ch, so only
  // its in_lock bit decides whether the lock is released.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      ARB: begin
        if (xfer && in_lock[pick_idx]) begin
          state_d   = LOCK;
          lock_ch_d = pick_idx;
        end
      end
      LOCK: begin
        if (xfer && !in_lock[lock_ch_q]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // Output logic: the locked channel is the only candidate in LOCK.
  always_comb begin
    grant     = pick_grant;
    grant_idx = pick_idx;
    if (state_q == LOCK) begin
      grant            = '0;
      grant[lock_ch_q] = in_valid[lock_ch_q];
      grant_idx        = lock_ch_q;
    end
  end
`else
  assign grant     = pick_grant;
  assign grant_idx = pick_idx;
`endif

  // -------------------------------------------------------------------------
  // Handshake. The output register can take a beat when it is empty or is
  // draining this cycle. Gating with rst_n keeps in_ready low during reset,
  // when the register is empty and load would otherwise be true.
  // -------------------------------------------------------------------------
  assign load     = !out_valid_q || out_ready;
  assign in_ready = (rst_n && load) ? grant : '0;
  assign xfer     = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_ch_d   = last_ch_q;
    if (xfer) begin
      // Covers the drain-and-reload case: the new beat replaces the old one.
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant_idx];
      out_sel_d   = grant_idx;
      last_ch_d   = grant_idx;
    end else if (out_ready) begin
      // Drained with nothing to replace it: payload and index hold.
      out_valid_d = 1'b0;
    end
  end

  // last_ch resets to CHANNELS-1 so the first search starts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_ch_q   <= SEL_W'(CHANNELS - 1);
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples values from before the edge.
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_ch_q   <= last_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule : rr_arb_mux

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default $bits(lc3b_word) (16): data width per channel.
REQ-002 SHALL have parameter CHANNELS, default 16, legal range 2..64: number of input channels.
REQ-003 SHALL have localparam SEL_W = $clog2(CHANNELS): width of the channel index.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  CHANNELS  per-channel request.
REQ-008 in_data  input  CHANNELS x WIDTH  per-channel payload, unpacked array indexed by channel.
REQ-009 in_ready  output  CHANNELS  per-channel accept, one-hot or zero.
REQ-010 in_lock  input  CHANNELS  hold grant after this beat; present only with ARB_MUX_LOCK_EN.
REQ-011 out_valid  output  1  output register holds a beat.
REQ-012 out_ready  input  1  downstream accepts the beat.
REQ-013 out_data  output  WIDTH  registered payload.
REQ-014 out_sel  output  SEL_W  channel index of the registered payload.

Function
REQ-015 SHALL compute load = !out_valid || out_ready.
REQ-016 SHALL assert in_ready[i] combinationally iff load && grant[i]; in_ready SHALL NOT depend on in_ready.
REQ-017 Grant in ARB state: first channel with in_valid=1, searching from last_ch+1 upward and wrapping CHANNELS-1 to 0.
REQ-018 Grant search SHALL wrap correctly for non-power-of-two CHANNELS, e.g. CHANNELS=3, last_ch=2 -> search 0,1,2.
REQ-019 A transfer occurs on a clock edge with in_valid[i] && in_ready[i].
REQ-020 On a transfer, out_data<=in_data[i], out_sel<=i, out_valid<=1, and last_ch<=i, all at the same edge.
REQ-021 Latency from transfer to out_valid=1 SHALL be 1 cycle.
REQ-022 Throughput SHALL be 1 beat/cycle while out_ready=1.
REQ-023 If out_valid && out_ready with no new transfer, out_valid<=0 and out_data/out_sel SHALL hold their values.
REQ-024 While out_valid && !out_ready, all in_ready SHALL be 0 and out_data/out_sel SHALL be stable.
REQ-025 Simultaneous drain and load SHALL replace the beat with no bubble cycle.
REQ-026 If no in_valid is set, no grant is made, in_ready=0, and last_ch is unchanged.
REQ-027 A channel dropping in_valid before being granted SHALL lose no state; arbitration is re-evaluated every cycle.

Reset
REQ-028 On rst_n=0, asynchronously: out_valid=0, out_data=0, out_sel=0, last_ch=CHANNELS-1 (channel 0 highest priority first), FSM=ARB.
REQ-029 A beat held in the output register at reset SHALL be discarded.
REQ-030 in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-031 Macro ARB_MUX_LOCK_EN SHALL select the lock feature.
REQ-032 With ARB_MUX_LOCK_EN: FSM states are ARB and LOCK.
REQ-033 ARB->LOCK on a transfer from channel i with in_lock[i]=1; lock_ch<=i.
REQ-034 In LOCK, grant is only lock_ch, regardless of other in_valid.
REQ-035 LOCK->ARB on a transfer from lock_ch with in_lock=0.
REQ-036 Without ARB_MUX_LOCK_EN: the in_lock port is absent, the FSM is permanently ARB, and no lock registers exist.

Structure
REQ-037 The lc3b_types package SHALL hold lc3b_word and a typedef arb_mux_state_t {ARB, LOCK}.
REQ-038 The rotating priority search SHALL be a sub-module rr_pick with parameter CHANNELS; inputs req, last_ch; outputs grant (one-hot) and grant_idx.

Verification (CHANNELS=16, WIDTH=16 unless stated)
REQ-039 ch3 valid, data 0x1234, out_ready=1 -> in_ready[3]=1 in cycle 0; cycle 1: out_valid=1, out_data=0x1234, out_sel=3.
REQ-040 All 16 channels valid, out_ready=1 for 17 cycles -> out_sel sequence 0,1,...,15,0 with no bubbles.
REQ-041 out_valid=1, out_ready=0 for 4 cycles -> in_ready=0 and out_data stable for those 4 cycles; out_ready=1 -> next grant loads the same edge the beat drains.
REQ-042 (LOCK_EN) ch2 and ch5 valid; ch2 in_lock=1,1,1,0 -> out_sel 2,2,2,2,5.
REQ-043 rst_n=0 mid-stream with out_valid=1 -> out_valid=0 immediately; after release, ch0 and ch1 valid -> ch0 granted first.
REQ-044 CHANNELS=3, all valid -> grants 0,1,2,0,1 (wrap check).
